// File: rtl/mult_pkg.sv
// mult_pkg
//   Shared constants and types for the array-multiplier issue/collect slice.
//   MULT_N   : operand width; products are 2*MULT_N bits wide.
//   MULT_LAT : cycles from operand load (ea/eb) to a valid product on p_out.
//   operand_t / product_t : unsigned operand and product containers.
package mult_pkg;

  localparam int MULT_N   = 8;
  localparam int MULT_LAT = 2;

  typedef logic [MULT_N-1:0]   operand_t;
  typedef logic [2*MULT_N-1:0] product_t;

endpackage

// File: rtl/mult_issue_ctrl_result_fifo.sv
// result_fifo
//   In-order FIFO with a registered head output. There is no bypass: a word
//   pushed into an empty FIFO becomes visible on dout the following cycle.
//   dout holds steady while the head is not popped.
//
// Ports
//   clk   in   clock, rising edge
//   rst   in   synchronous active-high reset (pointers, count, dout)
//   push  in   write din this cycle
//   din   in   WIDTH-bit write data
//   pop   in   retire the head entry (ignored when empty)
//   dout  out  WIDTH-bit registered head entry
//   empty out  no entries stored
//   full  out  DEPTH entries stored
//   count out  number of entries stored
module result_fifo
  import mult_pkg::*;
#(
  parameter int WIDTH = 2 * MULT_N,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             din,
  input  logic                         pop,
  output logic [WIDTH-1:0]             dout,
  output logic                         empty,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  // Pointer advance with wrap at DEPTH, so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_ptr_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_after_pop;
  logic             pop_ok;
  logic             head_from_din;
  logic             head_load;

  assign empty  = (cnt == '0);
  assign full   = (cnt == CNT_FULL);
  assign count  = cnt;
  assign pop_ok = pop && !empty;

  // The head register is loaded with whatever will sit at the read pointer
  // after this edge. If the FIFO drains to nothing and a push lands in the
  // same cycle, that new word is the head; otherwise it is already in mem.
  // When nothing is left at all, dout simply holds its last value.
  always_comb begin
    rd_ptr_n      = pop_ok ? ptr_inc(rd_ptr) : rd_ptr;
    cnt_after_pop = cnt - CNT_W'(pop_ok);
    head_from_din = push && (cnt_after_pop == '0);
    head_load     = head_from_din || (cnt_after_pop != '0);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      rd_ptr <= rd_ptr_n;
      case ({push, pop_ok})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout <= '0;
    end else if (head_load) begin
      dout <= head_from_din ? din : mem[rd_ptr_n];
    end
  end

endmodule

// File: rtl/mult_issue_ctrl.sv
// mult_issue_ctrl
//   Feeds a registered array multiplier from a valid/ready operand stream and
//   collects its products into a result FIFO. A credit counter (occ) limits
//   in-flight plus stored results to DEPTH, so a product arriving from the
//   multiplier always has a FIFO slot and the push is never gated. A LAT-deep
//   tag pipe marks the cycle in which p_in carries a product to be captured.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   in_valid   in   operand pair valid
//   in_ready   out  operand pair accepted when in_valid && in_ready
//   in_a/in_b  in   N-bit operands
//   in_keep_a  in   reuse the multiplier's held A (no A load)
//   in_keep_b  in   reuse the multiplier's held B (no B load)
//   ea/eb      out  multiplier operand-register enables
//   data_a/b   out  multiplier operands (pass-through of in_a/in_b)
//   p_in       in   2N-bit registered product from the multiplier
//   res_valid  out  result FIFO non-empty
//   res_ready  in   consumer pops the head when res_valid is high
//   res_data   out  2N-bit registered head product
//   busy       out  any operation in flight or stored
module mult_issue_ctrl
  import mult_pkg::*;
#(
  parameter int N     = MULT_N,
  parameter int LAT   = MULT_LAT,
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   in_a,
  input  logic [N-1:0]   in_b,
  input  logic           in_keep_a,
  input  logic           in_keep_b,
  output logic           ea,
  output logic           eb,
  output logic [N-1:0]   data_a,
  output logic [N-1:0]   data_b,
  input  logic [2*N-1:0] p_in,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [2*N-1:0] res_data,
  output logic           busy
);

  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam logic [OCC_W-1:0] OCC_MAX = OCC_W'(DEPTH);

  logic [OCC_W-1:0] occ;
  logic [OCC_W-1:0] occ_next;
  logic [LAT-1:0]   tag;
  logic             issue;
  logic             pop;
  logic             fifo_push;
  logic             fifo_empty;
  logic             fifo_full;
  logic [OCC_W-1:0] fifo_count;
  logic             fifo_stat_unused;

  // Credit is decoded from the occ register alone; a pop in this cycle frees
  // a slot only from the next cycle, which keeps in_ready off the
  // res_ready -> in_ready combinational path. Holding it low during reset
  // prevents any issue while rst is asserted.
  assign in_ready = !rst && (occ < OCC_MAX);
  assign issue    = in_valid && in_ready;

  assign ea     = issue && !in_keep_a;
  assign eb     = issue && !in_keep_b;
  assign data_a = in_a;
  assign data_b = in_b;

  assign res_valid = !fifo_empty;
  assign pop       = res_valid && res_ready;
  assign busy      = (occ != '0);

  // The oldest tag stage lines up with the cycle p_in holds the product.
  assign fifo_push = tag[LAT-1];

  // full and count are kept for observation only; credit makes the FIFO
  // unable to overflow.
  assign fifo_stat_unused = fifo_full | (|fifo_count);

  always_comb begin
    occ_next = occ;
    case ({issue, pop})
      2'b10:   occ_next = occ + OCC_W'(1);
      2'b01:   occ_next = occ - OCC_W'(1);
      default: occ_next = occ;
    endcase
  end

  // Stage boundary: issue -> tag pipe; reset clears tags so products still
  // inside the multiplier at reset are never captured.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ <= '0;
      tag <= '0;
    end else begin
      occ    <= occ_next;
      tag[0] <= issue;
      for (int i = 1; i < LAT; i++) begin
        tag[i] <= tag[i-1];
      end
    end
  end

  // Stage boundary: p_in -> result FIFO.
  result_fifo #(
    .WIDTH (2 * N),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (p_in),
    .pop   (pop),
    .dout  (res_data),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_mult_issue_ctrl.sv
module tb_mult_issue_ctrl;

  localparam int N     = 8;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   in_a;
  logic [N-1:0]   in_b;
  logic           in_keep_a;
  logic           in_keep_b;
  logic           ea;
  logic           eb;
  logic [N-1:0]   data_a;
  logic [N-1:0]   data_b;
  logic [2*N-1:0] p_in;
  logic           res_valid;
  logic           res_ready;
  logic [2*N-1:0] res_data;
  logic           busy;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  mult_issue_ctrl #(.N(N), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_keep_a (in_keep_a),
    .in_keep_b (in_keep_b),
    .ea        (ea),
    .eb        (eb),
    .data_a    (data_a),
    .data_b    (data_b),
    .p_in      (p_in),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .busy      (busy)
  );

  // Registered multiplier behind the block: operand registers, then product.
  logic [N-1:0]   m_a;
  logic [N-1:0]   m_b;
  logic [2*N-1:0] m_p;
  always @(posedge clk) begin
    if (rst) begin
      m_a <= '0;
      m_b <= '0;
      m_p <= '0;
    end else begin
      if (ea) m_a <= data_a;
      if (eb) m_b <= data_b;
      m_p <= {8'h00, m_a} * {8'h00, m_b};
    end
  end
  assign p_in = m_p;

  int tests = 0;
  int fails = 0;
  logic [15:0] sbq[$];
  int pop_cyc[$];
  int ovf = 0;
  int occ_max = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares every popped result against the scoreboard.
  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      pop_cyc.push_back(cyc);
      if (sbq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL result_unexpected: got %0d, expected no result (cycle %0d)", res_data, cyc);
      end else begin
        chk("result", 32'(res_data), 32'(sbq.pop_front()));
      end
    end
    if (dut.fifo_push && dut.fifo_full) ovf++;
    if (int'(dut.occ) > occ_max) occ_max = int'(dut.occ);
  end

  // Offer one pair; called just after a rising edge, returns just after the
  // edge following acceptance (or after max_wait refused cycles).
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic ka, input logic kb,
                      input logic [15:0] exp, input int max_wait, output int acc_cyc);
    int w;
    w = 0;
    acc_cyc = -1;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_keep_a = ka;
    in_keep_b = kb;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        chk("ea", 32'(ea), 32'(!ka));
        chk("eb", 32'(eb), 32'(!kb));
        chk("data_a", 32'(data_a), 32'(a));
        chk("data_b", 32'(data_b), 32'(b));
        sbq.push_back(exp);
        acc_cyc = cyc;
        @(posedge clk); #1;
        break;
      end
      if (w >= max_wait) begin
        tests++;
        fails++;
        $display("FAIL accept_timeout: got no accept in %0d cycles, expected accept (a=%0d b=%0d)", w + 1, a, b);
        @(posedge clk); #1;
        break;
      end
      w++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_keep_a = 1'b0;
    in_keep_b = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sbq.size() != 0 && w < 60) begin
      @(negedge clk);
      w++;
    end
    chk("drain_queue_empty", 32'(sbq.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int t0;
    int t1;
    int k;
    rst = 1'b1;
    in_valid = 1'b1;
    in_a = 8'd3;
    in_b = 8'd3;
    in_keep_a = 1'b0;
    in_keep_b = 1'b0;
    res_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ea", 32'(ea), 32'd0);
    chk("rst_eb", 32'(eb), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_data", 32'(res_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;

    // 1. Single op, latency 3.
    res_ready = 1'b1;
    send(8'd12, 8'd13, 1'b0, 1'b0, 16'd156, 0, t0);
    @(negedge clk);
    chk("t1_valid_c1", 32'(res_valid), 32'd0);
    @(negedge clk);
    chk("t1_valid_c2", 32'(res_valid), 32'd0);
    @(negedge clk);
    chk("t1_valid_c3", 32'(res_valid), 32'd1);
    chk("t1_data_c3", 32'(res_data), 32'd156);
    chk("t1_busy_c3", 32'(busy), 32'd1);
    @(negedge clk);
    chk("t1_valid_c4", 32'(res_valid), 32'd0);
    chk("t1_busy_c4", 32'(busy), 32'd0);
    @(posedge clk); #1;

    // 2. Backpressure.
    res_ready = 1'b0;
    send(8'd255, 8'd255, 1'b0, 1'b0, 16'd65025, 0, t0);
    send(8'd1, 8'd1, 1'b0, 1'b0, 16'd1, 0, t1);
    send(8'd2, 8'd3, 1'b0, 1'b0, 16'd6, 0, t1);
    send(8'd0, 8'd9, 1'b0, 1'b0, 16'd0, 0, t1);
    in_valid = 1'b1;
    in_a = 8'd4;
    in_b = 8'd4;
    @(negedge clk);
    chk("t2_in_ready_full", 32'(in_ready), 32'd0);
    chk("t2_full_cycle", 32'(cyc), 32'(t0 + 4));
    chk("t2_head", 32'(res_data), 32'd65025);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t2_in_ready_hold", 32'(in_ready), 32'd0);
    chk("t2_head_stable", 32'(res_data), 32'd65025);
    @(posedge clk); #1;
    res_ready = 1'b1;
    k = cyc;
    send(8'd4, 8'd4, 1'b0, 1'b0, 16'd16, 3, t1);
    chk("t2_accept_cycle", 32'(t1), 32'(k + 1));
    drain();

    // 3. Operand reuse; the ignored operand carries a junk value.
    send(8'd7, 8'd9, 1'b0, 1'b0, 16'd63, 0, t0);
    send(8'd99, 8'd10, 1'b1, 1'b0, 16'd70, 0, t1);
    send(8'd3, 8'd77, 1'b0, 1'b1, 16'd30, 0, t1);
    drain();

    // 4. Throughput.
    repeat (3) @(posedge clk);
    #1;
    occ_max = 0;
    pop_cyc.delete();
    for (int i = 0; i < 16; i++) begin
      send(8'(i), 8'(i + 1), 1'b0, 1'b0, 16'(i * (i + 1)), 0, t1);
      if (i == 0) t0 = t1;
    end
    drain();
    chk("t4_pop_count", 32'(pop_cyc.size()), 32'd16);
    if (pop_cyc.size() >= 16) begin
      chk("t4_first_pop", 32'(pop_cyc[0]), 32'(t0 + 3));
      chk("t4_last_pop", 32'(pop_cyc[15]), 32'(t0 + 18));
    end
    chk("t4_occ_max", 32'(occ_max), 32'd3);

    // 5. Reset mid-flight.
    send(8'd5, 8'd5, 1'b0, 1'b0, 16'd25, 0, t0);
    send(8'd6, 8'd6, 1'b0, 1'b0, 16'd36, 0, t1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sbq.delete();
    @(negedge clk);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_in_ready", 32'(in_ready), 32'd1);
    chk("t5_valid_c3", 32'(res_valid), 32'd0);
    for (int c = 4; c <= 8; c++) begin
      @(negedge clk);
      chk("t5_valid_quiet", 32'(res_valid), 32'd0);
    end
    @(posedge clk); #1;
    pop_cyc.delete();
    send(8'd2, 8'd2, 1'b0, 1'b0, 16'd4, 0, t0);
    drain();
    chk("t5_pop_count", 32'(pop_cyc.size()), 32'd1);
    if (pop_cyc.size() >= 1) chk("t5_latency", 32'(pop_cyc[0]), 32'(t0 + 3));

    // 6. Full boundary: pop and offer in the same cycle.
    res_ready = 1'b0;
    send(8'd10, 8'd10, 1'b0, 1'b0, 16'd100, 0, t0);
    send(8'd11, 8'd11, 1'b0, 1'b0, 16'd121, 0, t1);
    send(8'd12, 8'd12, 1'b0, 1'b0, 16'd144, 0, t1);
    send(8'd13, 8'd13, 1'b0, 1'b0, 16'd169, 0, t1);
    in_valid = 1'b1;
    in_a = 8'd3;
    in_b = 8'd5;
    res_ready = 1'b1;
    @(negedge clk);
    chk("t6_in_ready_pop_cycle", 32'(in_ready), 32'd0);
    chk("t6_res_valid", 32'(res_valid), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t6_in_ready_next", 32'(in_ready), 32'd1);
    chk("t6_ea", 32'(ea), 32'd1);
    if (in_ready) sbq.push_back(16'd15);
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();

    chk("push_while_full", 32'(ovf), 32'd0);
    chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
